// File: rtl/audio_voice_scheduler.sv
// -----------------------------------------------------------------------------
// audio_voice_scheduler
//   Shares the single square-wave audio voice between NUM_REQ requesters.
//   Request pulses are latched as pending bits. The lowest pending index is
//   granted and its tone plays for the requested number of cycles. A silence
//   gap follows each completed note. A higher-priority request arriving during
//   a note abandons that note and takes the voice immediately.
//
// Ports
//   CLOCK_50          : system clock
//   reset             : synchronous, active-high
//   req               : per-requester 1-cycle request pulse (index 0 = highest)
//   req_half_period   : per-requester tone half period, slice i = [19i+18:19i]
//   req_duration      : per-requester note length in cycles, DUR_W bits each
//   audio_out_allowed : controller FIFO has space
//   left/right_audio_out : registered sample (+AMPLITUDE / -AMPLITUDE / 0)
//   write_audio_out   : sample write strobe
//   active_id         : granted requester, valid while busy
//   busy              : high in LOAD and PLAY
//   done              : 1-cycle pulse when a note completes normally
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | voice free, waiting for any pending request
//   LOAD  | one cycle: grant lowest pending index, latch its parameters
//   PLAY  | tone output, duration counting down, preemption possible
//   GAP   | silence for GAP_CYCLES after a completed note
// -----------------------------------------------------------------------------
module audio_voice_scheduler #(
  parameter int          NUM_REQ    = 4,
  parameter logic [31:0] AMPLITUDE  = 32'd10000000,
  parameter int          DUR_W      = 26,
  parameter int          GAP_CYCLES = 500000,
  localparam int         ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*19-1:0]    req_half_period,
  input  logic [NUM_REQ*DUR_W-1:0] req_duration,
  input  logic                     audio_out_allowed,
  output logic [31:0]              left_audio_out,
  output logic [31:0]              right_audio_out,
  output logic                     write_audio_out,
  output logic [ID_W-1:0]          active_id,
  output logic                     busy,
  output logic [NUM_REQ-1:0]       done
);

  localparam int              GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t             r_state;
  logic [NUM_REQ-1:0] r_pending;
  logic [ID_W-1:0]    r_active_id;
  logic [18:0]        r_half_period;
  logic [18:0]        r_hp_cnt;
  logic [DUR_W-1:0]   r_dur_cnt;
  logic               r_phase;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [31:0]        r_sample;

  state_t             w_state_nxt;
  logic [NUM_REQ-1:0] w_pending_nxt;
  logic [ID_W-1:0]    w_active_nxt;
  logic [18:0]        w_hp_per_nxt;
  logic [18:0]        w_hp_cnt_nxt;
  logic [DUR_W-1:0]   w_dur_nxt;
  logic               w_phase_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic [NUM_REQ-1:0] w_done;
  logic [31:0]        w_sample_nxt;

  logic [ID_W-1:0]    w_grant;
  logic [18:0]        w_grant_hp;
  logic [DUR_W-1:0]   w_grant_dur;
  logic               w_preempt;

  // Lowest pending index wins; scanning downward lets the last hit be the lowest.
  always_comb begin
    w_grant     = '0;
    w_grant_hp  = '0;
    w_grant_dur = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_grant     = ID_W'(i);
        w_grant_hp  = req_half_period[19*i +: 19];
        w_grant_dur = req_duration[DUR_W*i +: DUR_W];
      end
    end
  end

  always_comb begin
    w_preempt = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_pending[i] && (ID_W'(i) < r_active_id)) w_preempt = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pending     <= '0;
      r_active_id   <= '0;
      r_half_period <= '0;
      r_hp_cnt      <= '0;
      r_dur_cnt     <= '0;
      r_phase       <= 1'b1;
      r_gap_cnt     <= '0;
      r_sample      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pending     <= w_pending_nxt;
      r_active_id   <= w_active_nxt;
      r_half_period <= w_hp_per_nxt;
      r_hp_cnt      <= w_hp_cnt_nxt;
      r_dur_cnt     <= w_dur_nxt;
      r_phase       <= w_phase_nxt;
      r_gap_cnt     <= w_gap_nxt;
      r_sample      <= w_sample_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending | req;
    w_active_nxt  = r_active_id;
    w_hp_per_nxt  = r_half_period;
    w_hp_cnt_nxt  = r_hp_cnt;
    w_dur_nxt     = r_dur_cnt;
    w_phase_nxt   = r_phase;
    w_gap_nxt     = r_gap_cnt;
    w_done        = '0;

    case (r_state)
      S_IDLE: begin
        if (|r_pending) w_state_nxt = S_LOAD;
      end

      S_LOAD: begin
        w_active_nxt           = w_grant;
        w_pending_nxt[w_grant] = 1'b0;
        w_hp_per_nxt           = w_grant_hp;
        w_hp_cnt_nxt           = '0;
        w_phase_nxt            = 1'b1;
        w_dur_nxt              = w_grant_dur;
        if (w_grant_dur == '0) begin
          w_done[w_grant] = 1'b1;
          w_state_nxt     = S_GAP;
          w_gap_nxt       = GAP_LOAD;
        end else begin
          w_state_nxt = S_PLAY;
        end
      end

      S_PLAY: begin
        if (r_hp_cnt == r_half_period) begin
          w_hp_cnt_nxt = '0;
          w_phase_nxt  = ~r_phase;
        end else begin
          w_hp_cnt_nxt = r_hp_cnt + 19'd1;
        end
        if (r_dur_cnt > DUR_W'(1)) w_dur_nxt = r_dur_cnt - DUR_W'(1);
        // A note on its final cycle completes even if a preemptor is waiting.
        if (r_dur_cnt == DUR_W'(1)) begin
          w_done[r_active_id] = 1'b1;
          w_state_nxt         = S_GAP;
          w_gap_nxt           = GAP_LOAD;
        end else if (w_preempt) begin
          w_pending_nxt[r_active_id] = 1'b0;
          w_state_nxt                = S_LOAD;
        end
      end

      S_GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
        else                 w_gap_nxt   = r_gap_cnt - GAP_W'(1);
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The sample register is loaded from next-state values so the sample lines
  // up with the PLAY cycle it belongs to.
  always_comb begin
    w_sample_nxt = '0;
    if (w_state_nxt == S_PLAY && w_hp_per_nxt != '0)
      w_sample_nxt = w_phase_nxt ? AMPLITUDE : -AMPLITUDE;
  end

  assign left_audio_out  = r_sample;
  assign right_audio_out = r_sample;
  assign write_audio_out = audio_out_allowed && !reset;
  assign busy            = (r_state == S_LOAD) || (r_state == S_PLAY);
  assign active_id       = (r_state == S_LOAD) ? w_grant : r_active_id;
  assign done            = w_done & {NUM_REQ{~reset}};

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// -----------------------------------------------------------------------------
// tb_audio_voice_scheduler
//   Drives directed scenarios and randomized request traffic into
//   audio_voice_scheduler and compares every cycle against a behavioural
//   model that tracks notes by elapsed play time rather than by counters.
//   No ports; generates CLOCK_50 and prints one summary line.
// -----------------------------------------------------------------------------
module tb_audio_voice_scheduler;

  localparam int          NR  = 4;
  localparam int          DW  = 26;
  localparam int          GAP = 16;
  localparam logic [31:0] AMP = 32'd10000000;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;
  localparam int M_GAP  = 3;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*19-1:0]  req_half_period = '0;
  logic [NR*DW-1:0]  req_duration = '0;
  logic              audio_out_allowed = 1'b1;
  logic [31:0]       left_audio_out;
  logic [31:0]       right_audio_out;
  logic              write_audio_out;
  logic [1:0]        active_id;
  logic              busy;
  logic [NR-1:0]     done;

  audio_voice_scheduler #(.GAP_CYCLES(GAP)) dut (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
    .req               (req),
    .req_half_period   (req_half_period),
    .req_duration      (req_duration),
    .audio_out_allowed (audio_out_allowed),
    .left_audio_out    (left_audio_out),
    .right_audio_out   (right_audio_out),
    .write_audio_out   (write_audio_out),
    .active_id         (active_id),
    .busy              (busy),
    .done              (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_pass = 0;

  int hp_cfg[NR];
  int dur_cfg[NR];

  // behavioural model
  int       m_mode;
  bit [3:0] m_pend;
  int       m_id, m_hp, m_dur, m_k, m_gap;
  bit       m_valid = 1'b0;

  // outputs captured in the most recent cycle
  logic [31:0] c_sample;
  logic [3:0]  c_done;
  logic        c_busy, c_write;
  logic [1:0]  c_id;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int lowest(input bit [3:0] p);
    for (int i = 0; i < NR; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic compare_outputs();
    int g, eid;
    logic [31:0] es;
    logic [3:0]  ed;
    logic        eb;
    g  = lowest(m_pend);
    eb = (m_mode == M_LOAD) || (m_mode == M_PLAY);
    es = 32'd0;
    if (m_mode == M_PLAY && m_hp != 0)
      es = (((m_k / (m_hp + 1)) % 2) == 0) ? AMP : -AMP;
    ed = 4'd0;
    if (!reset) begin
      if (m_mode == M_LOAD && dur_cfg[g] == 0) ed[g] = 1'b1;
      if (m_mode == M_PLAY && m_k == m_dur - 1) ed[m_id] = 1'b1;
    end
    eid = (m_mode == M_LOAD) ? g : m_id;
    chk("write", write_audio_out, audio_out_allowed && !reset);
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("left", left_audio_out, es);
    chk("right", right_audio_out, es);
    if (eb) chk("active_id", active_id, eid);
  endtask

  task automatic model_advance();
    bit [3:0] clr;
    bit       hi;
    int       g;
    if (reset) begin
      m_mode = M_IDLE; m_pend = 0; m_k = 0; m_id = 0; m_valid = 1'b1;
      return;
    end
    if (!m_valid) return;
    clr = 0;
    case (m_mode)
      M_IDLE: if (m_pend != 0) m_mode = M_LOAD;
      M_LOAD: begin
        g = lowest(m_pend);
        m_id = g; m_hp = hp_cfg[g]; m_dur = dur_cfg[g]; m_k = 0; clr[g] = 1'b1;
        if (m_dur == 0) begin m_mode = M_GAP; m_gap = GAP; end
        else m_mode = M_PLAY;
      end
      M_PLAY: begin
        hi = 1'b0;
        for (int j = 0; j < m_id; j++) if (m_pend[j]) hi = 1'b1;
        if (m_k == m_dur - 1) begin m_mode = M_GAP; m_gap = GAP; end
        else if (hi) begin m_mode = M_LOAD; clr[m_id] = 1'b1; end
        else m_k++;
      end
      default: begin
        m_gap--;
        if (m_gap == 0) m_mode = M_IDLE;
      end
    endcase
    m_pend = (m_pend | req) & ~clr;
  endtask

  task automatic run_cycle(input logic [3:0] r, input logic allow, input logic rst);
    req = r;
    audio_out_allowed = allow;
    reset = rst;
    for (int i = 0; i < NR; i++) begin
      req_half_period[19*i +: 19] = 19'(hp_cfg[i]);
      req_duration[DW*i +: DW]    = DW'(dur_cfg[i]);
    end
    #1;
    if (m_valid) compare_outputs();
    c_sample = left_audio_out; c_done = done; c_busy = busy;
    c_write = write_audio_out; c_id = active_id;
    @(posedge CLOCK_50);
    model_advance();
    @(negedge CLOCK_50);
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(4'b0000, 1'b1, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t_a, t_b, cnt, bad;
    logic [3:0] r;
    for (int i = 0; i < NR; i++) begin hp_cfg[i] = 0; dur_cfg[i] = 0; end
    @(negedge CLOCK_50);
    repeat (3) run_cycle(4'b0000, 1'b1, 1'b1);
    idle(2);

    // single note, hp=4 dur=20
    hp_cfg[2] = 4; dur_cfg[2] = 20;
    run_cycle(4'b0100, 1'b1, 1'b0);
    idle(1);
    idle(1);
    chk("t1_load_busy", c_busy, 1'b1);
    chk("t1_load_id", c_id, 2'd2);
    chk("t1_load_sample", c_sample, 32'd0);
    for (int k = 0; k < 20; k++) begin
      idle(1);
      chk("t1_sample", c_sample, (k < 5 || (k >= 10 && k < 15)) ? 32'd10000000 : 32'hFF676980);
      if (k == 19) chk("t1_done", c_done, 4'b0100);
    end
    idle(1);
    chk("t1_gap_busy", c_busy, 1'b0);
    chk("t1_gap_sample", c_sample, 32'd0);
    idle(GAP + 4);

    // simultaneous requests 3 and 1
    hp_cfg[1] = 2; dur_cfg[1] = 6; hp_cfg[3] = 3; dur_cfg[3] = 8;
    t_a = -1; t_b = -1;
    run_cycle(4'b1010, 1'b1, 1'b0);
    for (int t = 1; t <= 45; t++) begin
      idle(1);
      if (t == 2) chk("t2_first_id", c_id, 2'd1);
      if (c_done[1] && t_a < 0) t_a = t;
      if (c_done[3] && t_b < 0) t_b = t;
    end
    chk("t2_done1_cycle", t_a, 8);
    chk("t2_done3_cycle", t_b, 34);
    idle(GAP + 4);

    // preemption of a long note by requester 0
    hp_cfg[3] = 10; dur_cfg[3] = 1000; hp_cfg[0] = 3; dur_cfg[0] = 30;
    t_a = -1; cnt = 0; bad = 0;
    run_cycle(4'b1000, 1'b1, 1'b0);
    for (int t = 1; t <= 170; t++) begin
      run_cycle((t == 103) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
      if (t == 104) chk("t3_still_3", c_id, 2'd3);
      if (t == 105) begin
        chk("t3_load_busy", c_busy, 1'b1);
        chk("t3_load_id", c_id, 2'd0);
      end
      if (c_done[3]) bad++;
      if (c_done[0] && t_a < 0) t_a = t;
      if (t >= 152 && c_busy) cnt++;
    end
    chk("t3_no_done3", bad, 0);
    chk("t3_done0_cycle", t_a, 135);
    chk("t3_no_resume", cnt, 0);
    idle(GAP + 4);

    // zero duration, then silent rest
    hp_cfg[1] = 5; dur_cfg[1] = 0;
    run_cycle(4'b0010, 1'b1, 1'b0);
    idle(2);
    chk("t4_zero_done", c_done, 4'b0010);
    chk("t4_zero_busy", c_busy, 1'b1);
    bad = 0;
    for (int t = 0; t < 20; t++) begin idle(1); if (c_sample != 0) bad++; end
    chk("t4_zero_silent", bad, 0);
    idle(GAP);
    hp_cfg[1] = 0; dur_cfg[1] = 50;
    run_cycle(4'b0010, 1'b1, 1'b0);
    idle(2);
    cnt = 0;
    for (int t = 0; t < 50; t++) begin
      idle(1);
      if (c_busy && c_sample == 0) cnt++;
      if (t == 49) chk("t4_rest_done", c_done, 4'b0010);
    end
    chk("t4_rest_cycles", cnt, 50);
    idle(1);
    chk("t4_rest_end", c_busy, 1'b0);
    idle(GAP + 4);

    // FIFO full mid-note
    hp_cfg[2] = 4; dur_cfg[2] = 60;
    t_a = -1; bad = 0;
    run_cycle(4'b0100, 1'b1, 1'b0);
    for (int t = 1; t <= 70; t++) begin
      run_cycle(4'b0000, !(t >= 20 && t < 50), 1'b0);
      if (t >= 20 && t < 50 && c_write) bad++;
      if (c_done[2] && t_a < 0) t_a = t;
    end
    chk("t5_write_low", bad, 0);
    chk("t5_done_cycle", t_a, 62);
    idle(GAP + 4);

    // reset mid-note with two pending requests
    hp_cfg[0] = 4; dur_cfg[0] = 100;
    hp_cfg[2] = 3; dur_cfg[2] = 10; hp_cfg[3] = 3; dur_cfg[3] = 10;
    run_cycle(4'b0001, 1'b1, 1'b0);
    idle(9);
    run_cycle(4'b1100, 1'b1, 1'b0);
    idle(9);
    run_cycle(4'b0000, 1'b1, 1'b1);
    chk("t6_rst_write", c_write, 1'b0);
    chk("t6_rst_done", c_done, 4'b0000);
    idle(1);
    chk("t6_busy", c_busy, 1'b0);
    chk("t6_sample", c_sample, 32'd0);
    bad = 0;
    for (int t = 0; t < 40; t++) begin idle(1); if (c_busy || c_done != 0) bad++; end
    chk("t6_quiet", bad, 0);

    // randomized traffic
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NR; i++) begin
        hp_cfg[i]  = $urandom_range(0, 7);
        dur_cfg[i] = $urandom_range(0, 40);
      end
      for (int t = 0; t < 500; t++) begin
        r = 4'b0000;
        for (int i = 0; i < NR; i++) if ($urandom_range(0, 39) == 0) r[i] = 1'b1;
        run_cycle(r, $urandom_range(0, 4) != 0, $urandom_range(0, 599) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
